// File: rtl/alu_wb_if.sv
// alu_wb_if: ALU-result intake and register-file writeback handshake bundle
interface alu_wb_if;
  logic       in_valid;
  logic       in_ready;
  logic [5:0] in_result;
  logic [2:0] in_dest;
  logic       in_wr_en;
  logic       in_cf;
  logic       in_sf;
  logic       in_zf;
  logic       in_flag_we;
  logic       out_valid;
  logic       out_ready;
  logic [5:0] out_result;
  logic [2:0] out_dest;
  modport master (
    output in_valid, in_result, in_dest, in_wr_en, in_cf, in_sf, in_zf, in_flag_we, out_ready,
    input  in_ready, out_valid, out_result, out_dest
  );
  modport slave (
    input  in_valid, in_result, in_dest, in_wr_en, in_cf, in_sf, in_zf, in_flag_we, out_ready,
    output in_ready, out_valid, out_result, out_dest
  );
endinterface

// File: rtl/alu_wb_stage.sv
// alu_wb_stage: queues ALU register writes toward writeback and holds the architectural flags
module alu_wb_stage #(
  parameter int DEPTH = 2,
  parameter int CW    = 3
) (
  input  logic          clk,
  input  logic          rst,
  alu_wb_if.slave       bus,
  input  logic          flag_load,
  input  logic [2:0]    flag_din,
  output logic          cf_flag,
  output logic          sf_flag,
  output logic          zf_flag,
  output logic [CW-1:0] occupancy
);
  localparam int AW = (DEPTH > 2) ? 2 : 1;
  localparam logic [AW-1:0] LAST = AW'(DEPTH - 1);
  localparam logic [CW-1:0] FULL = CW'(DEPTH);
  logic [8:0]    mem [DEPTH];
  logic [AW-1:0] rd_ptr;
  logic [AW-1:0] wr_ptr;
  logic          accept;
  logic          push;
  logic          pop;
  // Popping frees a slot in the same cycle, so a full queue still accepts when drained.
  assign bus.in_ready  = (occupancy != FULL) | bus.out_ready;
  assign bus.out_valid = occupancy != '0;
  assign accept        = bus.in_valid & bus.in_ready;
  assign push          = accept & bus.in_wr_en;
  assign pop           = bus.out_valid & bus.out_ready;
  assign {bus.out_result, bus.out_dest} = bus.out_valid ? mem[rd_ptr] : 9'd0;
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= {bus.in_result, bus.in_dest};
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_ptr    <= '0;
      wr_ptr    <= '0;
      occupancy <= '0;
      {cf_flag, sf_flag, zf_flag} <= 3'b000;
    end else begin
      if (push) wr_ptr <= (wr_ptr == LAST) ? '0 : wr_ptr + 1'b1;
      if (pop) rd_ptr <= (rd_ptr == LAST) ? '0 : rd_ptr + 1'b1;
      if (push != pop) occupancy <= push ? occupancy + 1'b1 : occupancy - 1'b1;
      if (flag_load) {cf_flag, sf_flag, zf_flag} <= flag_din;
      else if (accept & bus.in_flag_we) {cf_flag, sf_flag, zf_flag} <= {bus.in_cf, bus.in_sf, bus.in_zf};
    end
  end
endmodule

// File: tb/tb_alu_wb_stage.sv
// tb_alu_wb_stage: directed vectors checked against a queue-based model plus literal expectations
module tb_alu_wb_stage;
  localparam int DEPTH = 2;
  localparam int CW    = 3;
  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          flag_load;
  logic [2:0]    flag_din;
  logic          cf_flag;
  logic          sf_flag;
  logic          zf_flag;
  logic [CW-1:0] occupancy;
  int            checks = 0;
  int            failures = 0;
  bit            cmp_en = 1'b0;
  logic [8:0]    m_q[$];
  logic [2:0]    m_flags;
  logic [5:0]    dut_log[$];
  alu_wb_if bus();
  alu_wb_stage #(.DEPTH(DEPTH), .CW(CW)) dut (
    .clk(clk), .rst(rst), .bus(bus), .flag_load(flag_load), .flag_din(flag_din),
    .cf_flag(cf_flag), .sf_flag(sf_flag), .zf_flag(zf_flag), .occupancy(occupancy)
  );
  always #5 clk = ~clk;
  task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", n, act, exp);
    end
  endtask
  // Model: a queue of pending writes and a flag word, updated per accepted op.
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_q.delete();
      m_flags = 3'b000;
    end else begin
      bit acc;
      acc = bus.in_valid && ((m_q.size() != DEPTH) || bus.out_ready);
      if (m_q.size() != 0 && bus.out_ready) void'(m_q.pop_front());
      if (acc && bus.in_wr_en) m_q.push_back({bus.in_result, bus.in_dest});
      if (flag_load) m_flags = flag_din;
      else if (acc && bus.in_flag_we) m_flags = {bus.in_cf, bus.in_sf, bus.in_zf};
    end
  end
  always @(negedge clk) begin
    if (cmp_en) begin
      chk("occupancy", 32'(occupancy), 32'(m_q.size()));
      chk("out_valid", 32'(bus.out_valid), 32'(m_q.size() != 0));
      chk("in_ready", 32'(bus.in_ready), 32'((m_q.size() != DEPTH) || bus.out_ready));
      chk("flags", 32'({cf_flag, sf_flag, zf_flag}), 32'(m_flags));
      if (m_q.size() != 0) chk("head", 32'({bus.out_result, bus.out_dest}), 32'(m_q[0]));
      if (bus.out_valid && bus.out_ready) dut_log.push_back(bus.out_result);
    end
  end
  task automatic drive(input logic v, input logic [5:0] r, input logic [2:0] d, input logic we,
                       input logic fwe, input logic [2:0] f, input logic ordy,
                       input logic fl, input logic [2:0] fd);
    bus.in_valid   = v;
    bus.in_result  = r;
    bus.in_dest    = d;
    bus.in_wr_en   = we;
    bus.in_flag_we = fwe;
    {bus.in_cf, bus.in_sf, bus.in_zf} = f;
    bus.out_ready  = ordy;
    flag_load      = fl;
    flag_din       = fd;
    @(posedge clk);
    #1;
  endtask
  task automatic set_idle(input logic ordy);
    bus.in_valid   = 1'b0;
    bus.in_result  = '0;
    bus.in_dest    = '0;
    bus.in_wr_en   = 1'b0;
    bus.in_flag_we = 1'b0;
    {bus.in_cf, bus.in_sf, bus.in_zf} = 3'b000;
    bus.out_ready  = ordy;
    flag_load      = 1'b0;
    flag_din       = 3'b000;
  endtask
  initial begin
    set_idle(1'b0);
    #2;
    chk("rst_occupancy", 32'(occupancy), 32'd0);
    chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
    chk("rst_out_data", 32'({bus.out_result, bus.out_dest}), 32'd0);
    chk("rst_flags", 32'({cf_flag, sf_flag, zf_flag}), 32'd0);
    #10 rst = 1'b0;
    @(posedge clk);
    #1;
    cmp_en = 1'b1;
    drive(1, 6'b000110, 3, 1, 1, 3'b100, 0, 0, 3'b000);
    chk("t1_out_valid", 32'(bus.out_valid), 32'd1);
    chk("t1_out_result", 32'(bus.out_result), 32'h06);
    chk("t1_out_dest", 32'(bus.out_dest), 32'd3);
    chk("t1_cf", 32'(cf_flag), 32'd1);
    chk("t1_occupancy", 32'(occupancy), 32'd1);
    drive(0, 0, 0, 0, 0, 3'b000, 1, 0, 3'b000);
    drive(1, 6'h05, 1, 1, 0, 3'b000, 0, 0, 3'b000);
    drive(1, 6'h0A, 2, 1, 0, 3'b000, 0, 0, 3'b000);
    drive(1, 6'h11, 4, 1, 0, 3'b000, 0, 0, 3'b000);
    chk("fill_in_ready", 32'(bus.in_ready), 32'd0);
    chk("fill_occupancy", 32'(occupancy), 32'd2);
    chk("fill_head", 32'(bus.out_result), 32'h05);
    drive(1, 6'h11, 4, 1, 0, 3'b000, 1, 0, 3'b000);
    chk("bp_occupancy", 32'(occupancy), 32'd2);
    chk("bp_head", 32'(bus.out_result), 32'h0A);
    drive(0, 0, 0, 0, 0, 3'b000, 1, 0, 3'b000);
    chk("bp_third", 32'(bus.out_result), 32'h11);
    drive(0, 0, 0, 0, 0, 3'b000, 1, 0, 3'b000);
    chk("order_count", 32'(dut_log.size()), 32'd4);
    if (dut_log.size() == 4) begin
      chk("order_0", 32'(dut_log[0]), 32'h06);
      chk("order_1", 32'(dut_log[1]), 32'h05);
      chk("order_2", 32'(dut_log[2]), 32'h0A);
      chk("order_3", 32'(dut_log[3]), 32'h11);
    end
    drive(1, 6'h3F, 7, 0, 1, 3'b001, 0, 0, 3'b000);
    chk("fo_occupancy", 32'(occupancy), 32'd0);
    chk("fo_flags", 32'({cf_flag, sf_flag, zf_flag}), 32'b001);
    drive(1, 6'h2A, 5, 1, 1, 3'b100, 0, 1, 3'b010);
    chk("prio_flags", 32'({cf_flag, sf_flag, zf_flag}), 32'b010);
    chk("prio_occupancy", 32'(occupancy), 32'd1);
    chk("prio_head", 32'(bus.out_result), 32'h2A);
    drive(0, 0, 0, 0, 0, 3'b000, 1, 0, 3'b000);
    dut_log.delete();
    for (int i = 1; i <= 5; i++) drive(1, 6'(i), 3'(i), 1, 0, 3'b000, 1, 0, 3'b000);
    drive(0, 0, 0, 0, 0, 3'b000, 1, 0, 3'b000);
    chk("wrap_count", 32'(dut_log.size()), 32'd5);
    for (int i = 0; i < 5 && i < dut_log.size(); i++) chk("wrap_value", 32'(dut_log[i]), 32'(i + 1));
    chk("wrap_occupancy", 32'(occupancy), 32'd0);
    dut_log.delete();
    drive(1, 6'h15, 1, 1, 0, 3'b000, 0, 1, 3'b111);
    drive(1, 6'h16, 2, 1, 0, 3'b000, 0, 0, 3'b000);
    set_idle(1'b0);
    chk("pre_rst_occupancy", 32'(occupancy), 32'd2);
    #3 rst = 1'b1;
    #1;
    chk("arst_occupancy", 32'(occupancy), 32'd0);
    chk("arst_out_valid", 32'(bus.out_valid), 32'd0);
    chk("arst_out_data", 32'({bus.out_result, bus.out_dest}), 32'd0);
    chk("arst_flags", 32'({cf_flag, sf_flag, zf_flag}), 32'd0);
    #2 rst = 1'b0;
    set_idle(1'b1);
    repeat (3) @(posedge clk);
    #1;
    chk("post_rst_writes", 32'(dut_log.size()), 32'd0);
    chk("post_rst_out_valid", 32'(bus.out_valid), 32'd0);
    cmp_en = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/alu_wb_stage.md
Name: alu_wb_stage

Overview:
- Downstream of the ALU's rotate/arith units, which produce 6-bit results plus CF/SF/ZF.
- Accepts one ALU result per handshake and queues register-file writes in a small FIFO toward the writeback port.
- Holds the architectural flag register. Its CF output feeds back as `cf_prev` into the next ALU operation (rotate by 0 preserves it).

Parameters:
- DEPTH, 2, number of writeback FIFO entries (legal values: 2 or 4).
- CW, 3, width of occupancy count (must hold 0..DEPTH).

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous active-high reset.
- in_valid  input  1  ALU result valid.
- in_ready  output  1  stage can accept this cycle.
- in_result  input  6  ALU result `r`.
- in_dest  input  3  destination register index.
- in_wr_en  input  1  1 = result written to register file; 0 = flags-only op (e.g. compare).
- in_cf  input  1  ALU carry flag.
- in_sf  input  1  ALU sign flag.
- in_zf  input  1  ALU zero flag.
- in_flag_we  input  1  1 = update flag register on acceptance.
- flag_load  input  1  direct flag restore strobe.
- flag_din  input  3  restore value {CF,SF,ZF}.
- out_valid  output  1  head entry valid.
- out_ready  input  1  register file consumes head.
- out_result  output  6  head entry data.
- out_dest  output  3  head entry register index.
- cf_flag  output  1  architectural CF (drives ALU `cf_prev`).
- sf_flag  output  1  architectural SF.
- zf_flag  output  1  architectural ZF.
- occupancy  output  CW  number of valid FIFO entries.

Behaviour:
- Clock and reset: one clock; reset is asynchronous and active-high. On `rst` assertion, immediately:
  - occupancy = 0, out_valid = 0, out_result = 0, out_dest = 0.
  - cf_flag = sf_flag = zf_flag = 0.
  - Read/write pointers = 0.
- Reset mid-operation discards all queued entries; nothing is written back.
- Handshake signals:
  - accept = in_valid & in_ready.
  - push = accept & in_wr_en.
  - pop = out_valid & out_ready.
- in_ready = (occupancy != DEPTH) | out_ready. This is combinational from out_ready and permits push and pop in the same cycle when full. It applies to flags-only ops as well, which keeps ordering of flag updates strictly in program order.
- FIFO:
  - Circular buffer; pointers wrap modulo DEPTH.
  - Push writes {in_result, in_dest} at the write pointer.
  - Pop advances the read pointer.
  - out_result/out_dest are the head entry, valid whenever out_valid = 1. They must be held stable while out_valid & ~out_ready.
  - out_valid = (occupancy != 0).
- Occupancy update per cycle:
  - push & ~pop → +1.
  - pop & ~push → −1.
  - both or neither → unchanged.
- Empty with simultaneous push: no bypass. The entry appears on out_valid the next cycle, so latency in→out is 1 cycle minimum.
- Flag register updates at the clock edge of acceptance, not at drain, so the next ALU op sees the new CF one cycle after acceptance.
  - If accept & in_flag_we: {cf,sf,zf} ← {in_cf,in_sf,in_zf}.
  - If flag_load: {cf,sf,zf} ← flag_din.
  - flag_load has priority over an ALU flag update in the same cycle; the ALU result is still accepted and queued normally.
  - Otherwise flags hold.
- Flags are stored exactly as supplied; this stage does not recompute ZF or SF from in_result.
- Illegal inputs: out_ready while empty is ignored. Inputs are don't-care when in_valid = 0.

Test Plan:
- Reset: assert `rst` asynchronously mid-cycle with 2 entries queued → occupancy = 0, out_valid = 0, all flags 0 without waiting for a clock edge.
- Single write, flags updated: push in_result = 6'b000110, in_dest = 3, in_flag_we = 1, CF=1/SF=0/ZF=0, with out_ready = 0 → next cycle out_valid = 1, out_result = 6'b000110, out_dest = 3, cf_flag = 1, occupancy = 1.
- Fill and backpressure (DEPTH=2, out_ready = 0): push 0x05 then 0x0A → in_ready = 0, third in_valid stalls. Raise out_ready → 0x05 pops and the stalled op is accepted the same cycle; order is 0x05, 0x0A, third.
- Flags-only op: in_wr_en = 0, in_flag_we = 1, ZF=1 → occupancy unchanged, zf_flag = 1 next cycle.
- Priority: flag_load = 1 with flag_din = 3'b010, same cycle as accept with in_flag_we = 1 and CF=1 → flags = {0,1,0}, and the result is queued.
- Wrap-around: 5 push/pop pairs through DEPTH=2 with distinct values 0x01..0x05 → outputs in order, occupancy never exceeds 2, no value lost or duplicated.
